// File: rtl/mac_fir_filter.sv
// Multi-channel FIR filter: one time-multiplexed multiplier walks every tap of the
// addressed channel's circular delay line, then presents a rounded, saturated result.
module mac_fir_filter #(
  parameter int DATA_W   = 24,
  parameter int COEF_W   = 12,
  parameter int TAPS     = 32,
  parameter int CHANNELS = 2,
  parameter int FRAC     = 11,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CW-1:0]     in_ch,
  input  logic              coef_we,
  input  logic [PW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_sat
);

  // Coefficients carry one extra bit so the reset gain of exactly +2^FRAC is representable.
  localparam int KW  = COEF_W + 1;
  localparam int PRW = DATA_W + KW;
  localparam int AW  = DATA_W + COEF_W + PW;
  localparam int RW  = AW + 1;
  localparam logic signed [KW-1:0] C_ONE = {{(KW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [RW-1:0] RND_C = {{(RW-1){1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MAC = 2'd1, ST_OUT = 2'd2} state_t;

  state_t                   state_r, state_nx_s;
  logic                     in_ready_r, out_valid_r, out_sat_r, prod_v_r;
  logic [DATA_W-1:0]        out_data_r;
  logic [CW-1:0]            out_ch_r, ch_r;
  logic signed [AW-1:0]     acc_r;
  logic signed [PRW-1:0]    prod_r;
  logic [PW-1:0]            k_r, rd_idx_r;
  logic [PW-1:0]            wr_ptr_r [CHANNELS];
  logic signed [DATA_W-1:0] buf_r    [CHANNELS][TAPS];
  logic signed [KW-1:0]     coef_r   [TAPS];

  logic                     ch_ok_s, addr_ok_s, take_s, last_s;
  logic signed [KW-1:0]     c_in_s;
  logic signed [PRW-1:0]    x_ext_s, c_ext_s, prod_s;
  logic signed [AW-1:0]     prod_ext_s, sum_s;
  logic signed [RW-1:0]     sum_ext_s, rnd_s, sh_s;
  logic [DATA_W:0]          res_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(TAPS - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    ptr_dec = (p == {PW{1'b0}}) ? PW'(TAPS - 1) : p - PW'(1);
  endfunction

  // Returns {clamped, value}; any bit above the result's sign that disagrees forces a clamp.
  function automatic logic [DATA_W:0] saturate(input logic signed [RW-1:0] v);
    logic [RW-DATA_W:0] top;
    top = v[RW-1:DATA_W-1];
    if ((&top) || (~|top)) saturate = {1'b0, v[DATA_W-1:0]};
    else if (v[RW-1])      saturate = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                   saturate = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Handshake qualification and the multiply / round / saturate datapath.
  always_comb begin
    ch_ok_s    = (int'(in_ch) < CHANNELS);
    addr_ok_s  = (int'(coef_addr) < TAPS);
    take_s     = in_valid && in_ready_r && ch_ok_s;
    last_s     = (k_r == PW'(TAPS - 1));
    c_in_s     = signed'(coef_data);
    x_ext_s    = buf_r[ch_r][rd_idx_r];
    c_ext_s    = coef_r[k_r];
    prod_s     = x_ext_s * c_ext_s;
    prod_ext_s = prod_r;
    sum_s      = acc_r + prod_ext_s;
    sum_ext_s  = sum_s;
    rnd_s      = sum_ext_s + RND_C;
    sh_s       = rnd_s >>> FRAC;
    res_s      = saturate(sh_s);
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) state_nx_s = ST_MAC;
        else        state_nx_s = ST_IDLE;
      end
      ST_MAC: begin
        if (last_s) state_nx_s = ST_OUT;
        else        state_nx_s = ST_MAC;
      end
      ST_OUT: begin
        if (out_valid_r && out_ready) state_nx_s = ST_IDLE;
        else                          state_nx_s = ST_OUT;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register, delay lines, coefficient bank and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_ch_r    <= {CW{1'b0}};
      out_sat_r   <= 1'b0;
      acc_r       <= {AW{1'b0}};
      prod_r      <= {PRW{1'b0}};
      prod_v_r    <= 1'b0;
      k_r         <= {PW{1'b0}};
      rd_idx_r    <= {PW{1'b0}};
      ch_r        <= {CW{1'b0}};
      for (int ci = 0; ci < CHANNELS; ci++) begin
        wr_ptr_r[ci] <= {PW{1'b0}};
        for (int ti = 0; ti < TAPS; ti++) buf_r[ci][ti] <= {DATA_W{1'b0}};
      end
      for (int ti = 0; ti < TAPS; ti++) coef_r[ti] <= {KW{1'b0}};
      coef_r[0] <= C_ONE;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            buf_r[in_ch][wr_ptr_r[in_ch]] <= in_data;
            wr_ptr_r[in_ch] <= ptr_inc(wr_ptr_r[in_ch]);
            rd_idx_r        <= wr_ptr_r[in_ch];
            ch_r            <= in_ch;
            acc_r           <= {AW{1'b0}};
            prod_v_r        <= 1'b0;
            k_r             <= {PW{1'b0}};
          end
        end
        ST_MAC: begin
          // The product is registered, so the last tap is folded in on the first OUT cycle.
          prod_r   <= prod_s;
          prod_v_r <= 1'b1;
          if (prod_v_r) acc_r <= sum_s;
          k_r      <= k_r + PW'(1);
          rd_idx_r <= ptr_dec(rd_idx_r);
        end
        ST_OUT: begin
          if (prod_v_r) begin
            acc_r       <= sum_s;
            prod_v_r    <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= res_s[DATA_W-1:0];
            out_sat_r   <= res_s[DATA_W];
            out_ch_r    <= ch_r;
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
      if (coef_we && (state_r == ST_IDLE) && addr_ok_s) coef_r[coef_addr] <= c_in_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_mac_fir_filter.sv
// Directed bench for mac_fir_filter: a vector table for single-result behaviour plus
// hand-written sequences for latency, back-pressure, mid-operation reset and long filters.
module tb_mac_fir_filter;
  localparam int TAPS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [23:0] in_data = 24'd0;
  logic [0:0]  in_ch = 1'b0;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = 5'd0;
  logic [11:0] coef_data = 12'd0;
  logic        out_valid, out_ready = 1'b1;
  logic [23:0] out_data;
  logic [0:0]  out_ch;
  logic        out_sat;

  int checks = 0;
  int failures = 0;

  mac_fir_filter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [11:0] c0;
    logic        ch;
    logic [23:0] din;
    logic [23:0] exp;
    logic        sat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_coef(input logic [4:0] a, input logic [11:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic send(input logic ch, input logic [23:0] d, input logic cw, input logic [11:0] cd);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    coef_we = cw; coef_addr = 5'd0; coef_data = cd;
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic get(output logic [23:0] d, output logic c, output logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    d = out_data; c = out_ch; s = out_sat;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic xact(input string nm, input logic ch, input logic [23:0] d, input logic cw,
                      input logic [11:0] cd, input logic [23:0] exp, input logic esat);
    logic [23:0] gd;
    logic        gc, gs;
    send(ch, d, cw, cd);
    get(gd, gc, gs);
    chk({nm, "_data"}, {8'd0, gd}, {8'd0, exp});
    chk({nm, "_ch_sat"}, {30'd0, gc, gs}, {30'd0, ch, esat});
  endtask

  initial begin
    vec_t        tbl [12];
    int          cnt, seen;
    logic [23:0] gd, hd;
    logic        gc, gs;

    tbl[0]  = '{1'b0, 12'h000, 1'b0, 24'h100000, 24'h100000, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 1'b1, 24'h123456, 24'h123456, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 1'b0, 24'h800000, 24'h800000, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 1'b1, 24'h7FFFFF, 24'h7FFFFF, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0};
    tbl[5]  = '{1'b1, 12'h400, 1'b0, 24'h000001, 24'h000001, 1'b0};
    tbl[6]  = '{1'b1, 12'h400, 1'b0, 24'hFFFFFF, 24'h000000, 1'b0};
    tbl[7]  = '{1'b1, 12'h400, 1'b1, 24'h000003, 24'h000002, 1'b0};
    tbl[8]  = '{1'b1, 12'h400, 1'b1, 24'hFFFFFD, 24'hFFFFFF, 1'b0};
    tbl[9]  = '{1'b1, 12'h800, 1'b0, 24'h800000, 24'h7FFFFF, 1'b1};
    tbl[10] = '{1'b1, 12'h800, 1'b0, 24'h000100, 24'hFFFF00, 1'b0};
    tbl[11] = '{1'b1, 12'h7FF, 1'b1, 24'h000800, 24'h0007FF, 1'b0};

    // Reset values, ready timing and first-result latency.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {5'd0, in_ready, out_valid, out_sat, out_ch, out_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 24'h100000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("latency_edges", cnt, TAPS + 1);
    chk("first_data", {8'd0, out_data}, 32'h00100000);
    chk("first_ch_sat", {30'd0, out_ch, out_sat}, 32'd0);
    @(posedge clk); #1;
    chk("idle_after_hs", {30'd0, in_ready, out_valid}, 32'd2);

    // Table: pass-through, rounding and single-tap saturation, with same-cycle coefficient writes.
    for (int i = 0; i < 12; i++)
      xact($sformatf("vec%0d", i), tbl[i].ch, tbl[i].din, tbl[i].wr, tbl[i].c0, tbl[i].exp, tbl[i].sat);

    // Coefficient write during MAC is ignored.
    do_reset();
    send(1'b0, 24'h0ABCDE, 1'b0, 12'h000);
    repeat (3) @(posedge clk);
    #1; coef_we = 1'b1; coef_addr = 5'd0; coef_data = 12'h000;
    @(posedge clk); #1; coef_we = 1'b0;
    get(gd, gc, gs);
    chk("mac_we_ignored", {8'd0, gd}, 32'h000ABCDE);
    xact("mac_we_next", 1'b0, 24'h001234, 1'b0, 12'h000, 24'h001234, 1'b0);

    // Back-pressure: result held, input blocked, pending sample taken only after the handshake.
    out_ready = 1'b0;
    send(1'b1, 24'h300000, 1'b0, 12'h000);
    get(gd, gc, gs);
    chk("stall_first", {8'd0, gd}, 32'h00300000);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 24'h0FEDCB;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", i), {5'd0, in_ready, out_valid, out_sat, out_ch, out_data},
          {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h300000});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_accept", {31'd0, in_ready}, 32'd0);
    get(gd, gc, gs);
    chk("stall_next_data", {8'd0, gd}, 32'h000FEDCB);
    chk("stall_next_ch", {31'd0, gc}, 32'd0);

    // Reset pulse during MAC cycle 5 aborts the result and restores pass-through.
    load_coef(5'd0, 12'h400);
    send(1'b0, 24'h200000, 1'b0, 12'h000);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("abort_no_valid", seen, 0);
    xact("abort_passthru", 1'b0, 24'h054321, 1'b0, 12'h000, 24'h054321, 1'b0);

    // Impulse response with c[k]=k+1; interleaved zero ch1 samples stay zero.
    do_reset();
    for (int k = 0; k < TAPS; k++) load_coef(5'(k), 12'(k + 1));
    xact("imp0", 1'b0, 24'h000800, 1'b0, 12'h000, 24'd1, 1'b0);
    for (int n = 1; n < TAPS; n++) begin
      xact($sformatf("imp%0d", n), 1'b0, 24'h000000, 1'b0, 12'h000, 24'(n + 1), 1'b0);
      if (n % 8 == 0)
        xact($sformatf("ch1_zero%0d", n), 1'b1, 24'h000000, 1'b0, 12'h000, 24'h000000, 1'b0);
    end

    // Full-scale inputs with maximal coefficients saturate in both directions.
    do_reset();
    for (int k = 0; k < TAPS; k++) load_coef(5'(k), 12'h7FF);
    for (int i = 0; i < TAPS; i++) begin
      send(1'b0, 24'h7FFFFF, 1'b0, 12'h000);
      get(gd, gc, gs);
      if (i == 0) chk("pos_first", {7'd0, gs, gd}, {7'd0, 1'b0, 24'h7FEFFF});
      hd = gd;
      hd[0] = hd[0] ^ 1'b0;
    end
    chk("pos_final", {7'd0, gs, gd}, {7'd0, 1'b1, 24'h7FFFFF});
    for (int i = 0; i < TAPS; i++) begin
      send(1'b0, 24'h800000, 1'b0, 12'h000);
      get(gd, gc, gs);
    end
    chk("neg_final", {7'd0, gs, gd}, {7'd0, 1'b1, 24'h800000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
